cdf_pass_ctrl: RTL

//  Sequences the CDF pipeline: queues "histogram bank ready" events for two ping-pong banks and runs one
//  CDF fetch pass per event. Drives the fetch stage's start/base-offset, waits for its done, then hands off
//  to the map stage. Sits between histogram accumulation and the Cdf_Fetch/map datapath.

---
 rtl/cdf_pass_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cdf_pass_ctrl.sv
// CDF pass sequencer: queues ping-pong histogram-bank-ready events and runs one
// fetch pass then one map pass per event, with a fetch watchdog and sticky error.
module cdf_pass_ctrl #(
  parameter int TIMEOUT_CYCLES = 600,
  parameter int TO_W           = 10
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic bank_ready_i,
  input  logic bank_id_i,
  output logic fetch_start_o,
  output logic fetch_base_o,
  input  logic fetch_done_i,
  output logic map_start_o,
  output logic map_bank_o,
  input  logic map_done_i,
  output logic busy_o,
  output logic pass_done_o,
  output logic pass_bank_o,
  output logic err_o,
  input  logic err_clr_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_MAP   = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        pending_q, pending_d;
  logic              cur_q, cur_d;
  logic              last_q, last_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;

  logic              sel_bank;
  logic [1:0]        clr_mask;
  logic [1:0]        set_mask;
  logic              timeout_hit;

  // With both banks waiting, alternate away from the bank served last.
  assign sel_bank = (pending_q == 2'b11) ? ~last_q : pending_q[1];
  assign set_mask = bank_ready_i ? (bank_id_i ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    wd_d        = wd_q;
    clr_mask    = 2'b00;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d = S_SETUP;
          cur_d   = sel_bank;
          last_d  = sel_bank;
        end
      end
      S_SETUP: begin
        state_d  = S_FETCH;
        wd_d     = '0;
        clr_mask = cur_q ? 2'b10 : 2'b01;
      end
      S_FETCH: begin
        // A done arriving on the last allowed cycle still wins over the timeout.
        if (fetch_done_i) begin
          state_d = S_DRAIN;
        end else if (wd_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_ERROR;
          timeout_hit = 1'b1;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_MAP;
      end
      S_MAP: begin
        if (map_done_i) state_d = S_IDLE;
      end
      S_ERROR: begin
        if (err_clr_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A new ready for the bank being retired re-arms it rather than being lost.
    pending_d = (pending_q & ~clr_mask) | set_mask;
    err_d     = timeout_hit ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      pending_q <= 2'b00;
      cur_q     <= 1'b0;
      last_q    <= 1'b1;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign fetch_start_o = (state_q == S_FETCH);
  assign fetch_base_o  = ((state_q == S_SETUP) || (state_q == S_FETCH)) & cur_q;
  assign map_start_o   = (state_q == S_DRAIN);
  assign map_bank_o    = ((state_q == S_DRAIN) || (state_q == S_MAP)) & cur_q;
  assign busy_o        = (state_q != S_IDLE);
  assign pass_done_o   = (state_q == S_MAP) & map_done_i;
  assign pass_bank_o   = pass_done_o & cur_q;
  assign err_o         = err_q;

endmodule
